// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared definitions for the AXI-Lite command master: FSM state encoding,
// AXI response codes and the fixed write strobe.
package axi_lite_cmd_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WR_B = 3'd2,
        ST_RD_A = 3'd3,
        ST_RD_R = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] WSTRB_ALL   = 4'b1111;

    // Anything other than OKAY is reported to the command side as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// Command/response streams plus the AXI-Lite master bus of the command master.
// The master modport is the block's view; slave is the view of whatever drives it.
interface axi_lite_cmd_master_if #(
    parameter int ADDR_N = 9,
    parameter int DATA_N = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_N-1:0] cmd_addr;
    logic [DATA_N-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_N-1:0] rsp_data;
    logic              rsp_err;

    logic [ADDR_N-1:0] m_axi_awaddr;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DATA_N-1:0] m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [ADDR_N-1:0] m_axi_araddr;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_N-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data, rsp_ready,
               m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
               m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_data, rsp_ready,
               m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
               m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready
    );

endinterface

// File: rtl/axi_lite_cmd_master.sv
// Turns single valid/ready commands into AXI-Lite reads or writes, one at a time,
// and returns the read data / error flag on a valid/ready response stream.
module axi_lite_cmd_master
    import axi_lite_cmd_master_pkg::*;
#(
    parameter int ADDR_N = 9,
    parameter int DATA_N = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    axi_lite_cmd_master_if.master bus
);

    state_t            state_q, state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_N-1:0] addr_q, addr_d;
    logic [DATA_N-1:0] data_q, data_d;
    logic [DATA_N-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    // Handshake outputs are real flops so reset can hold them low even though
    // reset itself lands in IDLE.
    logic cmd_ready_q, cmd_ready_d;
    logic rsp_valid_q, rsp_valid_d;
    logic awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d;
    logic bready_q, bready_d;
    logic arvalid_q, arvalid_d;
    logic rready_q, rready_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d    = bus.cmd_addr;
                    data_d    = bus.cmd_data;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus.cmd_we ? ST_WR : ST_RD_A;
                end
            end
            ST_WR: begin
                // AW and W retire independently; leave once both have gone.
                if (awvalid_q && bus.m_axi_awready) aw_done_d = 1'b1;
                if (wvalid_q && bus.m_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          state_d   = ST_WR_B;
            end
            ST_WR_B: begin
                if (bready_q && bus.m_axi_bvalid) begin
                    rsp_data_d = '0;
                    rsp_err_d  = resp_is_err(bus.m_axi_bresp);
                    state_d    = ST_RSP;
                end
            end
            ST_RD_A: begin
                if (arvalid_q && bus.m_axi_arready) state_d = ST_RD_R;
            end
            ST_RD_R: begin
                if (rready_q && bus.m_axi_rvalid) begin
                    rsp_data_d = bus.m_axi_rdata;
                    rsp_err_d  = resp_is_err(bus.m_axi_rresp);
                    state_d    = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_valid_q && bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear one edge later.
        cmd_ready_d = (state_d == ST_IDLE);
        awvalid_d   = (state_d == ST_WR) && !aw_done_d;
        wvalid_d    = (state_d == ST_WR) && !w_done_d;
        bready_d    = (state_d == ST_WR_B);
        arvalid_d   = (state_d == ST_RD_A);
        rready_d    = (state_d == ST_RD_R);
        rsp_valid_d = (state_d == ST_RSP);
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = data_q;
    assign bus.m_axi_wstrb   = WSTRB_ALL;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;

endmodule
